// File: rtl/data_responder.sv
// Word-addressed read responder with a wait-state FSM and an always-ready write port.
// Optional macro DATA_RESPONDER_WRITE_BYPASS_EN forwards a same-word write on the sampling edge.
module data_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        address_enable,
    input  logic [31:0] address,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        write_enable,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] COUNT_LOAD = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic [31:0]      data_reg;
    logic             load_data;
    logic [31:0]      read_word;

    logic [31:0] mem [DEPTH_WORDS];

    // Bits below the word and above the array size are deliberately dropped (wrap-around).
    logic [IDX_W-1:0] req_index;
    logic [IDX_W-1:0] write_index;
    assign req_index   = address[IDX_W+1:2];
    assign write_index = write_address[IDX_W+1:2];

    logic unused_address_bits;
    assign unused_address_bits = ^{address[31:IDX_W+2], address[1:0],
                                   write_address[31:IDX_W+2], write_address[1:0]};

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_index] <= write_data;
        end
    end

    // The array is read with the old contents on the sampling edge unless bypass is built in.
    always_comb begin
        read_word = mem[index_reg];
`ifdef DATA_RESPONDER_WRITE_BYPASS_EN
        if (write_enable && (write_index == index_reg)) begin
            read_word = write_data;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        index_next = index_reg;
        load_data  = 1'b0;
        data_valid = (state_reg == RESPOND);
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (address_enable) begin
                    index_next = req_index;
                    count_next = COUNT_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!address_enable) begin
                    state_next = IDLE;
                end else if (req_index != index_reg) begin
                    index_next = req_index;
                    count_next = COUNT_LOAD;
                end else if (count_reg != '0) begin
                    count_next = count_reg - 1'b1;
                end else begin
                    load_data  = 1'b1;
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            index_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            index_reg <= index_next;
            if (load_data) begin
                data_reg <= read_word;
            end
        end
    end

    assign data = data_reg;

endmodule

// File: tb/tb_data_responder.sv
// Directed bench for data_responder: latency, repeat, recapture, write forwarding, reset, wrap.
// Expected bypass behaviour follows DATA_RESPONDER_WRITE_BYPASS_EN when defined for the build.
module tb_data_responder;

    logic        clock;
    logic        reset_n;
    logic        address_enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_valid;
    logic        write_enable;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        busy;

    int total;
    int bad;

    data_responder dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .address_enable (address_enable),
        .address        (address),
        .data           (data),
        .data_valid     (data_valid),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_data     (write_data),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] value);
        write_enable  = 1'b1;
        write_address = addr;
        write_data    = value;
        tick();
        write_enable  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        #3;
        total++;
        if (data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=%h", data, 32'h0);
        end
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", data_valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        tick();
        reset_n = 1'b1;
        tick();
        $display("reset: outputs checked while reset_n low");
    endtask

    task automatic test_latency();
        logic exp_dv;
        logic exp_busy;
        write_word(32'h40, 32'h1234_5678);
        for (int c = 0; c <= 5; c++) begin
            address_enable = (c <= 3);
            address        = 32'h40;
            #3;
            exp_dv   = (c == 3);
            exp_busy = (c >= 1) && (c <= 3);
            total++;
            if (data_valid !== exp_dv) begin
                bad++;
                $display("FAIL latency_valid cycle=%0d got=%b want=%b", c, data_valid, exp_dv);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL latency_busy cycle=%0d got=%b want=%b", c, busy, exp_busy);
            end
            if (c >= 3) begin
                total++;
                if (data !== 32'h1234_5678) begin
                    bad++;
                    $display("FAIL latency_data cycle=%0d got=%h want=%h", c, data, 32'h1234_5678);
                end
            end
            tick();
        end
        $display("latency: read 0x40 -> %h", data);
    endtask

    task automatic test_back_to_back();
        logic exp_dv;
        for (int c = 0; c <= 8; c++) begin
            address_enable = (c <= 7);
            address        = 32'h40;
            #3;
            exp_dv = (c == 3) || (c == 7);
            total++;
            if (data_valid !== exp_dv) begin
                bad++;
                $display("FAIL b2b_valid cycle=%0d got=%b want=%b", c, data_valid, exp_dv);
            end
            if (exp_dv) begin
                total++;
                if (data !== 32'h1234_5678) begin
                    bad++;
                    $display("FAIL b2b_data cycle=%0d got=%h want=%h", c, data, 32'h1234_5678);
                end
            end
            tick();
        end
        $display("back_to_back: two completions for held request");
    endtask

    task automatic test_addr_change();
        logic exp_dv;
        write_word(32'h44, 32'hDEAD_BEEF);
        for (int c = 0; c <= 6; c++) begin
            address_enable = (c <= 4);
            address        = (c == 0) ? 32'h40 : 32'h44;
            #3;
            exp_dv = (c == 4);
            total++;
            if (data_valid !== exp_dv) begin
                bad++;
                $display("FAIL change_valid cycle=%0d got=%b want=%b", c, data_valid, exp_dv);
            end
            if (exp_dv) begin
                total++;
                if (data !== 32'hDEAD_BEEF) begin
                    bad++;
                    $display("FAIL change_data got=%h want=%h", data, 32'hDEAD_BEEF);
                end
            end
            tick();
        end
        $display("addr_change: 0x40 -> 0x44 returned %h", data);
    endtask

    task automatic test_write_forward();
        logic [31:0] exp_first;
        logic [31:0] req_addr   [3];
        int          wr_cycle   [3];
        logic [31:0] wr_value   [3];
        logic [31:0] exp_data   [3];
`ifdef DATA_RESPONDER_WRITE_BYPASS_EN
        exp_first = 32'hCAFE_F00D;
`else
        exp_first = 32'h1111_2222;
`endif
        write_word(32'h80, 32'h1111_2222);
        write_word(32'h84, 32'h0000_0000);
        // Same-edge write, follow-up read of the updated word, earlier-edge write.
        req_addr[0] = 32'h80; wr_cycle[0] = 2;  wr_value[0] = 32'hCAFE_F00D; exp_data[0] = exp_first;
        req_addr[1] = 32'h80; wr_cycle[1] = -1; wr_value[1] = 32'h0;         exp_data[1] = 32'hCAFE_F00D;
        req_addr[2] = 32'h84; wr_cycle[2] = 1;  wr_value[2] = 32'h5A5A_0001; exp_data[2] = 32'h5A5A_0001;
        for (int v = 0; v < 3; v++) begin
            for (int c = 0; c <= 4; c++) begin
                address_enable = (c <= 3);
                address        = req_addr[v];
                write_enable   = (c == wr_cycle[v]);
                write_address  = req_addr[v];
                write_data     = wr_value[v];
                #3;
                total++;
                if (data_valid !== (c == 3)) begin
                    bad++;
                    $display("FAIL fwd_valid vec=%0d cycle=%0d got=%b want=%b", v, c, data_valid, (c == 3));
                end
                if (c == 3) begin
                    total++;
                    if (data !== exp_data[v]) begin
                        bad++;
                        $display("FAIL fwd_data vec=%0d got=%h want=%h", v, data, exp_data[v]);
                    end
                end
                tick();
            end
            write_enable = 1'b0;
            $display("write_forward: vec=%0d addr=%h data=%h", v, req_addr[v], data);
        end
    endtask

    task automatic test_reset_mid();
        address_enable = 1'b1;
        address        = 32'h40;
        tick();
        reset_n = 1'b0;
        #3;
        total++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ctrl got=%b%b want=00", data_valid, busy);
        end
        total++;
        if (data !== 32'h0) begin
            bad++;
            $display("FAIL midreset_data got=%h want=%h", data, 32'h0);
        end
        tick();
        reset_n        = 1'b1;
        address_enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            total++;
            if (data_valid !== 1'b0) begin
                bad++;
                $display("FAIL midreset_quiet cycle=%0d got=%b want=0", c, data_valid);
            end
            tick();
        end
        for (int c = 0; c <= 4; c++) begin
            address_enable = (c <= 3);
            address        = 32'h40;
            #3;
            total++;
            if (data_valid !== (c == 3)) begin
                bad++;
                $display("FAIL postreset_valid cycle=%0d got=%b want=%b", c, data_valid, (c == 3));
            end
            if (c == 3) begin
                total++;
                if (data !== 32'h1234_5678) begin
                    bad++;
                    $display("FAIL postreset_data got=%h want=%h", data, 32'h1234_5678);
                end
            end
            tick();
        end
        $display("reset_mid: request abandoned, fresh read returned %h", data);
    endtask

    task automatic test_wrap();
        logic [31:0] rd_addr [2];
        logic [31:0] exp_val [2];
        write_word(32'h0000_0000, 32'hA5A5_A5A5);
        write_word(32'h0000_1004, 32'h0BAD_CAFE);
        rd_addr[0] = 32'h0000_1000; exp_val[0] = 32'hA5A5_A5A5;
        rd_addr[1] = 32'h0000_0007; exp_val[1] = 32'h0BAD_CAFE;
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c <= 4; c++) begin
                address_enable = (c <= 3);
                address        = rd_addr[v];
                #3;
                total++;
                if (data_valid !== (c == 3)) begin
                    bad++;
                    $display("FAIL wrap_valid vec=%0d cycle=%0d got=%b want=%b", v, c, data_valid, (c == 3));
                end
                if (c == 3) begin
                    total++;
                    if (data !== exp_val[v]) begin
                        bad++;
                        $display("FAIL wrap_data vec=%0d got=%h want=%h", v, data, exp_val[v]);
                    end
                end
                tick();
            end
            $display("wrap: addr=%h data=%h", rd_addr[v], data);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        clock          = 1'b0;
        reset_n        = 1'b1;
        address_enable = 1'b0;
        address        = 32'h0;
        write_enable   = 1'b0;
        write_address  = 32'h0;
        write_data     = 32'h0;
        #2;
        reset_n = 1'b0;
        tick();
        test_reset();
        test_latency();
        test_back_to_back();
        test_addr_change();
        test_write_forward();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
